// File: rtl/fetch_data_stager_if.sv
// Handshake and status bundle between the fetch controller / array feeder side
// (master) and the fetch data stager (slave).
interface fetch_data_stager_if #(
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 64
);
    localparam int FILL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    // Read side, driven by the fetch controller and the BRAM
    logic                  bram_en;
    logic [DATA_WIDTH-1:0] bram_rdata;
    logic                  tiles_control;
    logic                  fetch_done;

    // Stream towards the systolic-array feeder
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    // Status towards the arbiter
    logic [FILL_WIDTH-1:0] fill_level;
    logic                  room_32;
    logic                  tile_busy;
    logic                  overflow_err;
    logic                  tile_len_err;

    modport master (
        output bram_en, bram_rdata, tiles_control, fetch_done, out_ready,
        input  out_data, out_valid, out_last, fill_level, room_32, tile_busy,
               overflow_err, tile_len_err
    );

    modport slave (
        input  bram_en, bram_rdata, tiles_control, fetch_done, out_ready,
        output out_data, out_valid, out_last, fill_level, room_32, tile_busy,
               overflow_err, tile_len_err
    );
endinterface

// File: rtl/fetch_data_stager.sv
// Realigns BRAM read data by the fixed read latency, tags the last word of each
// tile and buffers the stream in a first-word fall-through FIFO.
module fetch_data_stager #(
    parameter int DATA_WIDTH = 256,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    fetch_data_stager_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] SHORT_LEN = CNT_WIDTH'(32);
    localparam logic [CNT_WIDTH-1:0] LONG_LEN  = CNT_WIDTH'(512);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_RETURN
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  tile_len, tile_len_nxt;
    logic [CNT_WIDTH-1:0]  wr_cnt, wr_cnt_nxt;
    logic [RD_LATENCY-1:0] vpipe;
    logic [CNT_WIDTH-1:0]  inflight, inflight_nxt;
    logic [ADDR_WIDTH:0]   count, count_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   head;

    logic wr_en, pop, full, do_push, ovf_set, len_err_set, last_tag, room_nxt;
    logic room_q, overflow_q, tile_len_err_q;

    // The returning word is valid exactly when the strobe reaches the last pipe stage
    assign wr_en   = vpipe[RD_LATENCY-1];
    assign full    = (count == (ADDR_WIDTH+1)'(FIFO_DEPTH));
    assign pop     = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign do_push = wr_en && (!full || pop);
    assign ovf_set = wr_en && full && !pop;

    // Reads still travelling through the BRAM pipe
    always_comb begin
        inflight_nxt = inflight;
        if (bus.bram_en && !wr_en)      inflight_nxt = inflight + CNT_WIDTH'(1);
        else if (!bus.bram_en && wr_en) inflight_nxt = inflight - CNT_WIDTH'(1);
    end

    // FIFO occupancy after this cycle's push and pop
    always_comb begin
        count_nxt = count;
        if (do_push && !pop)      count_nxt = count + (ADDR_WIDTH+1)'(1);
        else if (!do_push && pop) count_nxt = count - (ADDR_WIDTH+1)'(1);
    end

    // Room is judged against storage already promised to reads in flight
    assign room_nxt = (FIFO_DEPTH - int'(count_nxt) - int'(inflight_nxt)) >= 32;

    // Tile tracking: next state, word count, last-word tag and length errors
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_nxt    = state;
        tile_len_nxt = tile_len;
        wr_cnt_nxt   = wr_cnt;
        last_tag     = 1'b0;
        len_err_set  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A word arriving outside a tile is a stray read
                if (wr_en) len_err_set = 1'b1;
                if (bus.bram_en) begin
                    state_nxt    = ST_CAPTURE;
                    tile_len_nxt = bus.tiles_control ? SHORT_LEN : LONG_LEN;
                    wr_cnt_nxt   = '0;
                end
            end
            ST_CAPTURE, ST_RETURN: begin
                if (wr_en) begin
                    last_tag = (wr_cnt == tile_len - CNT_WIDTH'(1));
                    if (wr_cnt >= tile_len) len_err_set = 1'b1;
                    // Saturate so a runaway tile cannot wrap back onto the last-word index
                    if (wr_cnt != '1) wr_cnt_nxt = wr_cnt + CNT_WIDTH'(1);
                end
                if (state == ST_CAPTURE) begin
                    if (bus.fetch_done) state_nxt = ST_RETURN;
                end else if (inflight_nxt == '0) begin
                    state_nxt = ST_IDLE;
                    if (wr_cnt_nxt != tile_len) len_err_set = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register with its tile length and word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state    <= ST_IDLE;
            tile_len <= '0;
            wr_cnt   <= '0;
        end else if (flush) begin
            state    <= ST_IDLE;
            tile_len <= '0;
            wr_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            tile_len <= tile_len_nxt;
            wr_cnt   <= wr_cnt_nxt;
        end
    end

    // Valid pipe, in-flight count, FIFO pointers, room flag and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe          <= '0;
            inflight       <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            room_q         <= 1'b0;
            overflow_q     <= 1'b0;
            tile_len_err_q <= 1'b0;
        end else if (flush) begin
            vpipe          <= '0;
            inflight       <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            room_q         <= 1'b0;
            overflow_q     <= 1'b0;
            tile_len_err_q <= 1'b0;
        end else begin
            vpipe          <= (vpipe << 1) | RD_LATENCY'(bus.bram_en);
            inflight       <= inflight_nxt;
            count          <= count_nxt;
            if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop)     rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            room_q         <= room_nxt;
            overflow_q     <= overflow_q | ovf_set;
            tile_len_err_q <= tile_len_err_q | len_err_set;
        end
    end

    // FIFO storage write of {data, last_tag}
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy comes from count, and a reset would block RAM inference.
        if (do_push && !flush) mem[wr_ptr] <= {bus.bram_rdata, last_tag};
    end

    assign head             = mem[rd_ptr];
    assign bus.out_valid    = (count != '0);
    // Gated so reset/flush shows zeros instead of stale storage
    assign bus.out_data     = bus.out_valid ? head[DATA_WIDTH:1] : '0;
    assign bus.out_last     = bus.out_valid && head[0];
    assign bus.fill_level   = count;
    assign bus.room_32      = room_q;
    assign bus.tile_busy    = (state != ST_IDLE);
    assign bus.overflow_err = overflow_q;
    assign bus.tile_len_err = tile_len_err_q;
endmodule

// File: tb/tb_fetch_data_stager.sv
// Bench for fetch_data_stager: a hand-computed vector table, directed corner
// sequences and random traffic, all checked cycle by cycle against a queue model.
module tb_fetch_data_stager;
    localparam int DW    = 256;
    localparam int LAT   = 2;
    localparam int DEPTH = 64;
    localparam int CW    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    fetch_data_stager_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

    fetch_data_stager #(
        .DATA_WIDTH(DW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic en, tc, done, rdy, fl;
        logic valid;
        int   fill;
        logic busy, last, room, lerr;
    } vec_t;

    // Reference model: stored words, due cycles of reads in flight, tile bookkeeping
    word_t q[$];
    int    pend[$];
    int    cyc = 0;
    bit    in_tile = 0, done_seen = 0;
    int    tile_len = 0, words = 0;
    bit    m_ovf = 0, m_lenerr = 0, m_room = 0;

    int n_vec = 0, n_miss = 0;
    int pop_cnt = 0, last_cnt = 0, last_idx = -1, first_valid = -1, en_tick = 0;

    vec_t tbl[7];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend.delete();
        in_tile   = 0;
        done_seen = 0;
        tile_len  = 0;
        words     = 0;
        m_ovf     = 0;
        m_lenerr  = 0;
        m_room    = 0;
    endtask

    // One clock of the specification's rules, using the inputs set for this cycle
    task automatic model_step(input logic [DW-1:0] rd);
        bit wr, pop, lt;
        if (flush) begin
            model_reset();
        end else begin
            wr  = (pend.size() > 0) && (pend[0] == cyc);
            pop = (q.size() != 0) && bus.out_ready;
            lt  = 0;
            if (wr) begin
                if (!in_tile) m_lenerr = 1;
                else begin
                    lt = (words == tile_len - 1);
                    if (words >= tile_len) m_lenerr = 1;
                    words++;
                end
            end
            if (pop) void'(q.pop_front());
            if (wr) begin
                if (q.size() == DEPTH) m_ovf = 1;
                else q.push_back({rd, lt});
            end
            if (bus.bram_en) pend.push_back(cyc + LAT);
            if (wr) void'(pend.pop_front());
            if (!in_tile) begin
                if (bus.bram_en) begin
                    in_tile   = 1;
                    done_seen = 0;
                    tile_len  = bus.tiles_control ? 32 : 512;
                    words     = 0;
                end
            end else if (!done_seen) begin
                if (bus.fetch_done) done_seen = 1;
            end else if (pend.size() == 0) begin
                in_tile = 0;
                if (words != tile_len) m_lenerr = 1;
            end
            m_room = (DEPTH - q.size() - pend.size()) >= 32;
        end
    endtask

    task automatic compare_all();
        bit ev;
        ev = (q.size() != 0);
        check("out_valid", DW'(bus.out_valid), DW'(ev));
        check("fill_level", DW'(bus.fill_level), DW'(q.size()));
        if (ev) begin
            check("out_last", DW'(bus.out_last), DW'(q[0].last));
            check("out_data", bus.out_data, q[0].data);
        end else begin
            check("out_last", DW'(bus.out_last), DW'(1'b0));
        end
        check("room_32", DW'(bus.room_32), DW'(m_room));
        check("tile_busy", DW'(bus.tile_busy), DW'(in_tile));
        check("overflow_err", DW'(bus.overflow_err), DW'(m_ovf));
        check("tile_len_err", DW'(bus.tile_len_err), DW'(m_lenerr));
    endtask

    // Drive fresh random read data, advance model and DUT by one clock, compare
    task automatic tick();
        logic [DW-1:0] rd;
        for (int i = 0; i < DW / 32; i++) rd[i*32 +: 32] = $urandom();
        bus.bram_rdata = rd;
        if (bus.out_valid && bus.out_ready) begin
            if (bus.out_last) begin
                last_cnt++;
                last_idx = pop_cnt;
            end
            pop_cnt++;
        end
        model_step(rd);
        cyc++;
        @(posedge clk);
        #1;
        compare_all();
        if (bus.out_valid && first_valid < 0) first_valid = cyc;
    endtask

    task automatic idle_inputs(input logic rdy);
        bus.bram_en    = 1'b0;
        bus.fetch_done = 1'b0;
        bus.out_ready  = rdy;
        flush          = 1'b0;
    endtask

    task automatic pulse_flush();
        idle_inputs(1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clear_obs();
        pop_cnt     = 0;
        last_cnt    = 0;
        last_idx    = -1;
        first_valid = -1;
    endtask

    task automatic end_tile();
        bus.bram_en    = 1'b0;
        bus.fetch_done = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (bus.tile_busy && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_idle_bound", DW'(bus.tile_busy), DW'(1'b0));
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        bus.out_ready = 1'b1;
        while (bus.fill_level != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_bound", DW'(bus.fill_level), DW'(0));
    endtask

    function automatic vec_t mk(input logic en, tc, done, rdy, fl, valid, input int fill,
                                input logic busy, last, room, lerr);
        vec_t v;
        v.en = en; v.tc = tc; v.done = done; v.rdy = rdy; v.fl = fl;
        v.valid = valid; v.fill = fill; v.busy = busy; v.last = last;
        v.room = room; v.lerr = lerr;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            en tc dn rdy fl | valid fill busy last room lerr
        tbl[0] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        tbl[1] = mk(1, 1, 0, 0, 0,   0, 0, 1, 0, 1, 0);
        tbl[2] = mk(0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 0);
        tbl[3] = mk(0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 1);
        tbl[4] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 1);
        tbl[5] = mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        tbl[6] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);

        bus.bram_en = 1'b0; bus.bram_rdata = '0; bus.tiles_control = 1'b0;
        bus.fetch_done = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Hand-computed single-read tile: latency, early fetch_done, short-tile error
        foreach (tbl[i]) begin
            bus.bram_en = tbl[i].en; bus.tiles_control = tbl[i].tc;
            bus.fetch_done = tbl[i].done; bus.out_ready = tbl[i].rdy; flush = tbl[i].fl;
            tick();
            check($sformatf("tbl%0d_valid", i), DW'(bus.out_valid), DW'(tbl[i].valid));
            check($sformatf("tbl%0d_fill", i), DW'(bus.fill_level), DW'(tbl[i].fill));
            check($sformatf("tbl%0d_busy", i), DW'(bus.tile_busy), DW'(tbl[i].busy));
            check($sformatf("tbl%0d_last", i), DW'(bus.out_last), DW'(tbl[i].last));
            check($sformatf("tbl%0d_room", i), DW'(bus.room_32), DW'(tbl[i].room));
            check($sformatf("tbl%0d_lerr", i), DW'(bus.tile_len_err), DW'(tbl[i].lerr));
        end
        flush = 1'b0;

        // 32-word tile streamed at full rate
        pulse_flush();
        clear_obs();
        bus.out_ready = 1'b1; bus.tiles_control = 1'b1;
        en_tick = cyc;
        for (int i = 0; i < 32; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        end_tile();
        wait_idle(20);
        drain(20);
        check("t1_latency", DW'(first_valid - en_tick), DW'(LAT + 1));
        check("t1_words", DW'(pop_cnt), DW'(32));
        check("t1_last_count", DW'(last_cnt), DW'(1));
        check("t1_last_index", DW'(last_idx), DW'(31));
        check("t1_len_err", DW'(bus.tile_len_err), DW'(1'b0));

        // 70 reads into a stalled 64-deep FIFO
        pulse_flush();
        clear_obs();
        bus.tiles_control = 1'b0;
        for (int i = 0; i < 70; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        end_tile();
        repeat (4) tick();
        check("t2_fill", DW'(bus.fill_level), DW'(DEPTH));
        check("t2_overflow", DW'(bus.overflow_err), DW'(1'b1));
        check("t2_room", DW'(bus.room_32), DW'(1'b0));
        drain(100);
        check("t2_drained", DW'(pop_cnt), DW'(DEPTH));

        // Full FIFO with push and pop in the same cycle
        pulse_flush();
        bus.tiles_control = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        bus.bram_en = 1'b0;
        repeat (3) tick();
        check("t3_full", DW'(bus.fill_level), DW'(DEPTH));
        bus.bram_en = 1'b1;
        tick();
        bus.bram_en = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t3_fill_kept", DW'(bus.fill_level), DW'(DEPTH));
        check("t3_no_overflow", DW'(bus.overflow_err), DW'(1'b0));
        end_tile();
        wait_idle(20);
        drain(100);

        // Short tile: 31 of 32 words
        pulse_flush();
        bus.tiles_control = 1'b1;
        for (int i = 0; i < 31; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        end_tile();
        wait_idle(20);
        check("t4_len_err", DW'(bus.tile_len_err), DW'(1'b1));
        clear_obs();
        drain(50);
        check("t4_no_last", DW'(last_cnt), DW'(0));
        check("t4_words", DW'(pop_cnt), DW'(31));

        // Flush with words stored, reads in flight and a sticky error pending
        bus.out_ready = 1'b0; bus.tiles_control = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        bus.bram_en = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        check("t5_stored", DW'(bus.fill_level), DW'(10));
        pulse_flush();
        check("t5_fill", DW'(bus.fill_level), DW'(0));
        check("t5_valid", DW'(bus.out_valid), DW'(1'b0));
        check("t5_len_err", DW'(bus.tile_len_err), DW'(1'b0));
        repeat (4) tick();
        check("t5_inflight_dropped", DW'(bus.fill_level), DW'(0));

        // Asynchronous reset mid-tile, then a full 512-word tile
        pulse_flush();
        bus.out_ready = 1'b1; bus.tiles_control = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        bus.bram_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", DW'(bus.out_valid), DW'(1'b0));
        check("t6_rst_fill", DW'(bus.fill_level), DW'(0));
        check("t6_rst_last", DW'(bus.out_last), DW'(1'b0));
        check("t6_rst_room", DW'(bus.room_32), DW'(1'b0));
        check("t6_rst_busy", DW'(bus.tile_busy), DW'(1'b0));
        check("t6_rst_ovf", DW'(bus.overflow_err), DW'(1'b0));
        check("t6_rst_lerr", DW'(bus.tile_len_err), DW'(1'b0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < 512; i++) begin
            bus.bram_en = 1'b1;
            tick();
        end
        end_tile();
        wait_idle(20);
        drain(100);
        check("t6_words", DW'(pop_cnt), DW'(512));
        check("t6_last_count", DW'(last_cnt), DW'(1));
        check("t6_last_index", DW'(last_idx), DW'(511));
        check("t6_len_err", DW'(bus.tile_len_err), DW'(1'b0));

        // Random traffic against the model
        pulse_flush();
        for (int i = 0; i < 3000; i++) begin
            bus.bram_en       = 1'($urandom_range(0, 1));
            bus.tiles_control = 1'($urandom_range(0, 1));
            bus.fetch_done    = ($urandom_range(0, 15) == 0);
            bus.out_ready     = ($urandom_range(0, 3) != 0);
            flush             = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle_inputs(1'b1);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
